operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 128, vector register width in bits.
REQ-002 SHALL have parameter SCALAR_W, default 32, scalar register width in bits.
REQ-003 SHALL have parameter ADDR_W, default 6, register address width; bit 5 set means vector file, clear means scalar file.
REQ-004 SHALL have parameter NUM_REGS, default 25, registers per file (indices 0..24).
REQ-005 SHALL have ports, clock and reset first:
- clk, in, 1: single clock; one clock, all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: decoded instruction present.
- in_ready, out, 1: instruction accepted this cycle when high with in_valid.
- in_rs1, in, ADDR_W: source register 1 address.
- in_rs2, in, ADDR_W: source register 2 address.
- in_rd, in, ADDR_W: destination address.
- in_we, in, 1: instruction writes in_rd.
- in_ctrl, in, 16: opaque control word, passed through.
- rf_a1, out, ADDR_W: register-file read address 1.
- rf_a2, out, ADDR_W: register-file read address 2.
- rf_rd1, in, DATA_W: register-file read data 1.
- rf_rd2, in, DATA_W: register-file read data 2.
- wb_we, in, 1: writeback strobe, the same signal driving the register-file write enable.
- wb_addr, in, ADDR_W: writeback address.
- wb_data, in, DATA_W: writeback data.
- flush, in, 1: discard the held output entry.
- out_valid, out, 1: operand bundle valid.
- out_ready, in, 1: execute stage consumes the bundle.
- out_op1, out, DATA_W: operand 1.
- out_op2, out, DATA_W: operand 2.
- out_rd, out, ADDR_W: destination address.
- out_we, out, 1: destination write flag.
- out_ctrl, out, 16: control word.

Function
REQ-006 SHALL drive rf_a1=in_rs1 and rf_a2=in_rs2 combinationally.
REQ-007 SHALL keep a scoreboard of 2*NUM_REGS busy bits indexed by {addr[5], addr[4:0]}.
REQ-008 SHALL treat addresses 6'h00, 6'h20 and any addr[4:0]>=NUM_REGS as never busy; their operand value is 0 and they never set a busy bit.
REQ-009 SHALL flag a source hazard when rsN is busy, unless wb_we=1 and wb_addr==rsN in the same cycle.
REQ-010 SHALL flag a WAW hazard when in_we=1 and in_rd is busy after this cycle's writeback clear.
REQ-011 SHALL drive in_ready = !hazard & (!out_valid | out_ready) & !flush.
REQ-012 SHALL on accept (in_valid & in_ready) capture operands, rd, we and ctrl into the output register; out_valid=1 on the next edge (latency 1).
REQ-013 SHALL select each operand as: wb_data when wb_we and wb_addr==rsN (bypass); otherwise rf_rdN. Scalar sources SHALL zero-extend bits [SCALAR_W-1:0] to DATA_W.
REQ-014 SHALL hold all out_* stable while out_valid & !out_ready.
REQ-015 SHALL clear out_valid after out_ready & out_valid with no new accept.
REQ-016 SHALL set the busy bit for in_rd on accept when in_we=1.
REQ-017 SHALL clear the busy bit for wb_addr when wb_we=1.
REQ-018 SHALL let a set win over a clear on the same bit in the same cycle.
REQ-019 SHALL on flush clear out_valid next edge, and clear the busy bit of the held entry if out_we=1; flush with out_valid=0 has no effect.

Reset
REQ-020 SHALL on rst=1 at a clock edge clear all busy bits and set out_valid=0, out_op1=0, out_op2=0, out_rd=0, out_we=0, out_ctrl=0.
REQ-021 SHALL drive in_ready=0 during rst.
REQ-022 SHALL discard any in-flight entry when reset is asserted mid-operation.

Structure
REQ-023 SHALL take DATA_W, SCALAR_W, ADDR_W, NUM_REGS and a register-index helper from shared package proc_pkg.
REQ-024 SHALL implement the busy bits in one sub-module, reg_scoreboard: set port, clear port, two query ports.

Verification
REQ-025 Bench SHALL cover: accept rs1=6'h03 (rf_rd1=32'h0000_00AA, scalar) -> out_op1=128'h...00AA one cycle later, out_valid=1.
REQ-026 Bench SHALL cover: issue rd=6'h21 we=1, then rs1=6'h21 -> in_ready=0 until wb_we with wb_addr=6'h21 and wb_data=X; in that cycle accept with out_op1=X.
REQ-027 Bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, then drain in order.
REQ-028 Bench SHALL cover: rs1=6'h00, rs2=6'h3F -> both operands 0, no stall.
REQ-029 Bench SHALL cover: flush on held entry with rd=6'h05 we=1 -> out_valid=0, then rs1=6'h05 accepted without stall.
REQ-030 Bench SHALL cover: rst mid-stall with busy bits set -> all bits clear, out_valid=0, next instruction accepted immediately.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor parameters and register-address helpers.
// Address bit 5 selects the vector file; bits [4:0] index within a file.
package proc_pkg;

    localparam int DATA_W   = 128;
    localparam int SCALAR_W = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_REGS = 25;

    // r0 of each file and indices past the end of a file are hardwired to zero and never tracked.
    function automatic logic reg_tracked(input logic [ADDR_W-1:0] addr, input int nregs);
        return (addr[4:0] != 5'd0) && (int'(addr[4:0]) < nregs);
    endfunction

    // Flattened busy-bit index: scalar file first, vector file after it; untracked maps to slot 0.
    function automatic int reg_index(input logic [ADDR_W-1:0] addr, input int nregs);
        int idx;
        idx = int'(addr[4:0]);
        if (addr[ADDR_W-1])
            idx = idx + nregs;
        if (!reg_tracked(addr, nregs))
            idx = 0;
        return idx;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bits for both register files: one set port, a two-entry clear port,
// a two-address source query port and a destination query port.
module reg_scoreboard #(
    parameter int ADDR_W   = proc_pkg::ADDR_W,
    parameter int NUM_REGS = proc_pkg::NUM_REGS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic [1:0]             clr_en,
    input  logic [1:0][ADDR_W-1:0] clr_addr,
    input  logic [1:0][ADDR_W-1:0] src_addr,
    output logic [1:0]             src_busy,
    input  logic [ADDR_W-1:0]      dst_addr,
    output logic                   dst_busy
);
    import proc_pkg::*;

    localparam int SB_BITS = 2 * NUM_REGS;
    localparam int IDX_W   = $clog2(SB_BITS);

    logic [SB_BITS-1:0] busy;
    logic [SB_BITS-1:0] busy_nxt;

    function automatic logic [IDX_W-1:0] slot(input logic [ADDR_W-1:0] addr);
        return IDX_W'(reg_index(addr, NUM_REGS));
    endfunction

    // Clears are applied first so a same-cycle set on the same bit wins.
    always_comb begin
        busy_nxt = busy;
        for (int c = 0; c < 2; c++) begin
            if (clr_en[c] && reg_tracked(clr_addr[c], NUM_REGS))
                busy_nxt[slot(clr_addr[c])] = 1'b0;
        end
        if (set_en && reg_tracked(set_addr, NUM_REGS))
            busy_nxt[slot(set_addr)] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_comb begin
        for (int q = 0; q < 2; q++)
            src_busy[q] = reg_tracked(src_addr[q], NUM_REGS) && busy[slot(src_addr[q])];
        dst_busy = reg_tracked(dst_addr, NUM_REGS) && busy[slot(dst_addr)];
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources, bypasses same-cycle writeback, stalls on
// RAW/WAW hazards and holds one operand bundle for the execute stage.
module operand_fetch #(
    parameter int DATA_W   = proc_pkg::DATA_W,
    parameter int SCALAR_W = proc_pkg::SCALAR_W,
    parameter int ADDR_W   = proc_pkg::ADDR_W,
    parameter int NUM_REGS = proc_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_we,
    input  logic [15:0]       in_ctrl,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_we,
    output logic [15:0]       out_ctrl
);
    import proc_pkg::*;

    logic [1:0]        src_busy;
    logic              dst_busy;
    logic              src_hazard;
    logic              waw_hazard;
    logic              accept;
    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;

    // Untracked registers read as zero; scalar sources keep only their low SCALAR_W bits.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              bypass_we,
        input logic [ADDR_W-1:0] bypass_addr,
        input logic [DATA_W-1:0] bypass_data
    );
        logic [DATA_W-1:0] v;
        if (!reg_tracked(addr, NUM_REGS))
            v = '0;
        else if (bypass_we && bypass_addr == addr)
            v = bypass_data;
        else
            v = rf_data;
        if (!addr[ADDR_W-1])
            v = DATA_W'(v[SCALAR_W-1:0]);
        return v;
    endfunction

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    reg_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept & in_we),
        .set_addr (in_rd),
        .clr_en   ({flush & out_valid & out_we, wb_we}),
        .clr_addr ({out_rd, wb_addr}),
        .src_addr ({in_rs2, in_rs1}),
        .src_busy (src_busy),
        .dst_addr (in_rd),
        .dst_busy (dst_busy)
    );

    // A writeback landing this cycle resolves the hazard on its own address.
    always_comb begin
        src_hazard = (src_busy[0] && !(wb_we && wb_addr == in_rs1)) ||
                     (src_busy[1] && !(wb_we && wb_addr == in_rs2));
        waw_hazard = in_we && dst_busy && !(wb_we && wb_addr == in_rd);
        in_ready   = !rst && !src_hazard && !waw_hazard && (!out_valid || out_ready) && !flush;
        accept     = in_valid && in_ready;
        op1_sel    = pick_operand(in_rs1, rf_rd1, wb_we, wb_addr, wb_data);
        op2_sel    = pick_operand(in_rs2, rf_rd2, wb_we, wb_addr, wb_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_rd    <= '0;
            out_we    <= 1'b0;
            out_ctrl  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_op1   <= op1_sel;
            out_op2   <= op2_sel;
            out_rd    <= in_rd;
            out_we    <= in_we;
            out_ctrl  <= in_ctrl;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: table-driven vectors plus hand-written
// stall, bypass, flush and reset sequences, with an expected-bundle queue.
module tb_operand_fetch;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   in_rs1;
    logic [5:0]   in_rs2;
    logic [5:0]   in_rd;
    logic         in_we;
    logic [15:0]  in_ctrl;
    logic [5:0]   rf_a1;
    logic [5:0]   rf_a2;
    logic [127:0] rf_rd1;
    logic [127:0] rf_rd2;
    logic         wb_we;
    logic [5:0]   wb_addr;
    logic [127:0] wb_data;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_op1;
    logic [127:0] out_op2;
    logic [5:0]   out_rd;
    logic         out_we;
    logic [15:0]  out_ctrl;

    typedef struct {
        logic [5:0]   rs1;
        logic [5:0]   rs2;
        logic [5:0]   rd;
        logic         we;
        logic [15:0]  ctrl;
        logic [127:0] rd1;
        logic [127:0] rd2;
        logic [127:0] op1;
        logic [127:0] op2;
    } vec_t;

    typedef struct {
        logic [127:0] op1;
        logic [127:0] op2;
        logic [5:0]   rd;
        logic         we;
        logic [15:0]  ctrl;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    vec_t tbl[9];
    int   n_vec;
    int   n_miss;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_we     (in_we),
        .in_ctrl   (in_ctrl),
        .rf_a1     (rf_a1),
        .rf_a2     (rf_a2),
        .rf_rd1    (rf_rd1),
        .rf_rd2    (rf_rd2),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_rd    (out_rd),
        .out_we    (out_we),
        .out_ctrl  (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                                input logic we, input logic [15:0] ctrl,
                                input logic [127:0] rd1, input logic [127:0] rd2,
                                input logic [127:0] op1, input logic [127:0] op2);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.we = we; v.ctrl = ctrl;
        v.rd1 = rd1; v.rd2 = rd2; v.op1 = op1; v.op2 = op2;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid = 1'b1;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_rd    = v.rd;
        in_we    = v.we;
        in_ctrl  = v.ctrl;
        rf_rd1   = v.rd1;
        rf_rd2   = v.rd2;
        cur_exp.op1  = v.op1;
        cur_exp.op2  = v.op2;
        cur_exp.rd   = v.rd;
        cur_exp.we   = v.we;
        cur_exp.ctrl = v.ctrl;
    endtask

    // One clock: sample mid-cycle, retire a consumed bundle, record an accepted one.
    task automatic step(input bit chk, input logic exp_rdy, input string nm);
        exp_t e;
        @(negedge clk);
        if (chk)
            checkOutput({nm, "_ready"}, 128'(in_ready), 128'(exp_rdy));
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_bundle: got op1 %h, expected no output", out_op1);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_op1", out_op1, e.op1);
                checkOutput("out_op2", out_op2, e.op2);
                checkOutput("out_meta", 128'({out_rd, out_we, out_ctrl}), 128'({e.rd, e.we, e.ctrl}));
            end
        end
        if (!rst && in_valid && in_ready)
            exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1; in_valid = 1'b0; wb_we = 1'b0; flush = 1'b0;
        step(0, 1'b0, "");
        step(0, 1'b0, "");
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int cycles);
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++)
            step(0, 1'b0, "");
        checkOutput("queue_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        vec_t v;
        n_vec = 0; n_miss = 0;
        rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_we = 1'b0;
        in_ctrl = '0; rf_rd1 = '0; rf_rd2 = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;

        tbl[0] = mk(6'h03, 6'h04, 6'h00, 1'b0, 16'h1111,
                    128'hDEADBEEF_DEADBEEF_DEADBEEF_000000AA, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_12345678,
                    128'h000000AA, 128'h12345678);
        tbl[1] = mk(6'h21, 6'h22, 6'h00, 1'b0, 16'h2222,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'hCAFEF00D_00000000_11111111_80000001,
                    128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'hCAFEF00D_00000000_11111111_80000001);
        tbl[2] = mk(6'h00, 6'h3F, 6'h00, 1'b0, 16'h3333, {128{1'b1}}, {128{1'b1}}, 128'h0, 128'h0);
        tbl[3] = mk(6'h20, 6'h19, 6'h00, 1'b0, 16'h4444, {32{4'h5}}, {32{4'hA}}, 128'h0, 128'h0);
        tbl[4] = mk(6'h18, 6'h38, 6'h00, 1'b0, 16'h5555,
                    128'h99999999_88888888_77777777_66666666, 128'h44444444_33333333_22222222_11111111,
                    128'h66666666, 128'h44444444_33333333_22222222_11111111);
        tbl[5] = mk(6'h01, 6'h02, 6'h3F, 1'b1, 16'h6666,
                    128'h0, 128'hFFFFFFFF_00000000_00000000_FFFFFFFF, 128'h0, 128'hFFFFFFFF);
        tbl[6] = mk(6'h3F, 6'h1F, 6'h39, 1'b1, 16'h7777, {128{1'b1}}, {128{1'b1}}, 128'h0, 128'h0);
        tbl[7] = mk(6'h38, 6'h24, 6'h00, 1'b1, 16'h8888, 128'h1, 128'h2, 128'h1, 128'h2);
        tbl[8] = mk(6'h00, 6'h00, 6'h00, 1'b0, 16'hFFFF, 128'h5, 128'h6, 128'h0, 128'h0);

        $display("[TB] reset state");
        step(0, 1'b0, "");
        step(0, 1'b0, "");
        checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
        checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
        checkOutput("rst_out_op1", out_op1, 128'h0);
        checkOutput("rst_out_op2", out_op2, 128'h0);
        checkOutput("rst_out_meta", 128'({out_rd, out_we, out_ctrl}), 128'd0);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i]);
            #1;
            checkOutput("rf_addr", 128'({rf_a1, rf_a2}), 128'({tbl[i].rs1, tbl[i].rs2}));
            step(1, 1'b1, "tbl");
        end
        drain(2);

        $display("[TB] RAW stall released by writeback bypass");
        doReset();
        applyStimulus(mk(6'h01, 6'h02, 6'h21, 1'b1, 16'hA001, 128'hFF_00000011, 128'h22, 128'h11, 128'h22));
        step(1, 1'b1, "raw_issue");
        applyStimulus(mk(6'h21, 6'h00, 6'h00, 1'b0, 16'hA002, 128'hBAD, 128'h5,
                         128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0, 128'h0));
        step(1, 1'b0, "raw_stall1");
        step(1, 1'b0, "raw_stall2");
        wb_we = 1'b1; wb_addr = 6'h21; wb_data = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;
        step(1, 1'b1, "raw_bypass");
        wb_we = 1'b0;
        drain(2);

        $display("[TB] back-pressure hold");
        doReset();
        applyStimulus(mk(6'h01, 6'h02, 6'h03, 1'b0, 16'hB001, 128'hA1, 128'hA2, 128'hA1, 128'hA2));
        step(1, 1'b1, "hold_a");
        out_ready = 1'b0;
        applyStimulus(mk(6'h04, 6'h05, 6'h06, 1'b0, 16'hB002, 128'hB1, 128'hB2, 128'hB1, 128'hB2));
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, "hold_stall");
            checkOutput("hold_valid", 128'(out_valid), 128'd1);
            checkOutput("hold_op1", out_op1, 128'hA1);
            checkOutput("hold_ctrl", 128'(out_ctrl), 128'hB001);
        end
        out_ready = 1'b1;
        step(1, 1'b1, "hold_release");
        drain(2);

        $display("[TB] flush releases destination");
        doReset();
        out_ready = 1'b0;
        applyStimulus(mk(6'h01, 6'h02, 6'h05, 1'b1, 16'hC001, 128'h1, 128'h2, 128'h1, 128'h2));
        step(1, 1'b1, "flush_issue");
        in_valid = 1'b0;
        flush = 1'b1;
        step(1, 1'b0, "flush");
        flush = 1'b0;
        if (exp_q.size() > 0)
            void'(exp_q.pop_back());
        checkOutput("flush_valid", 128'(out_valid), 128'd0);
        out_ready = 1'b1;
        applyStimulus(mk(6'h05, 6'h00, 6'h00, 1'b0, 16'hC002, 128'h55, 128'h9, 128'h55, 128'h0));
        step(1, 1'b1, "after_flush");
        drain(2);

        $display("[TB] WAW stall and set-over-clear");
        doReset();
        applyStimulus(mk(6'h01, 6'h02, 6'h09, 1'b1, 16'hD001, 128'h3, 128'h4, 128'h3, 128'h4));
        step(1, 1'b1, "waw_first");
        applyStimulus(mk(6'h01, 6'h02, 6'h09, 1'b1, 16'hD002, 128'h7, 128'h8, 128'h7, 128'h8));
        step(1, 1'b0, "waw_stall");
        wb_we = 1'b1; wb_addr = 6'h09; wb_data = 128'h1234;
        step(1, 1'b1, "waw_release");
        wb_we = 1'b0;
        applyStimulus(mk(6'h09, 6'h00, 6'h00, 1'b0, 16'hD003, 128'hEE, 128'h0,
                         128'h9ABCDEF0, 128'h0));
        step(1, 1'b0, "set_wins");
        wb_we = 1'b1; wb_addr = 6'h09; wb_data = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_9ABCDEF0;
        step(1, 1'b1, "scalar_bypass");
        wb_we = 1'b0;
        drain(2);

        $display("[TB] reset during stall");
        doReset();
        out_ready = 1'b0;
        applyStimulus(mk(6'h01, 6'h02, 6'h07, 1'b1, 16'hE001, 128'h1, 128'h2, 128'h1, 128'h2));
        step(1, 1'b1, "mid_issue");
        v = mk(6'h07, 6'h00, 6'h08, 1'b1, 16'hE002, 128'h77, 128'h0, 128'h77, 128'h0);
        applyStimulus(v);
        step(1, 1'b0, "mid_stall");
        rst = 1'b1;
        step(0, 1'b0, "");
        checkOutput("mid_rst_ready", 128'(in_ready), 128'd0);
        checkOutput("mid_rst_valid", 128'(out_valid), 128'd0);
        checkOutput("mid_rst_op1", out_op1, 128'h0);
        exp_q.delete();
        rst = 1'b0;
        out_ready = 1'b1;
        step(1, 1'b1, "post_rst");
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
